// File: rtl/divider_seq_hs.sv
// divider_seq_hs: multi-cycle restoring divider with signed/unsigned mode,
// divide-by-zero and overflow flags, and valid/ready handshakes on both sides.
// One quotient bit per cycle, MSB first; operands are reduced to magnitudes on
// accept and the signs are reapplied in a single fix-up cycle before DONE.
module divider_seq_hs #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero,
    output logic         overflow
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   prem_q;      // partial remainder magnitude
    logic [N-1:0]   quo_q;       // dividend bits shift out, quotient bits shift in
    logic [N-1:0]   dsr_q;       // divisor magnitude
    logic           neg_quo_q;
    logic           neg_rem_q;
    logic           dz_q;
    logic           ovf_q;

    logic           in_ready_q;
    logic           out_valid_q;
    logic [N-1:0]   quotient_q;
    logic [N-1:0]   remainder_q;
    logic           div_zero_q;
    logic           overflow_q;

    logic [N:0]     rem_shift;
    logic [N-1:0]   prem_d;
    logic [N-1:0]   quo_d;
    logic           a_neg;
    logic           b_neg;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           ovf_det;
    logic [N-1:0]   quo_fix;
    logic [N-1:0]   rem_fix;
    logic [N-1:0]   min_val;

    // Restoring step, operand magnitudes on accept, and sign fix-up values
    always_comb begin
        min_val   = '0;
        min_val[N-1] = 1'b1;

        // Compare at N+1 bits; the difference itself always fits in N bits
        rem_shift = {prem_q, quo_q[N-1]};
        if (rem_shift >= {1'b0, dsr_q}) begin
            prem_d = rem_shift[N-1:0] - dsr_q;
            quo_d  = {quo_q[N-2:0], 1'b1};
        end else begin
            prem_d = rem_shift[N-1:0];
            quo_d  = {quo_q[N-2:0], 1'b0};
        end

        a_neg   = is_signed & dividend[N-1];
        b_neg   = is_signed & divisor[N-1];
        a_mag   = a_neg ? -dividend : dividend;
        b_mag   = b_neg ? -divisor  : divisor;
        ovf_det = is_signed && (dividend == min_val) && (divisor == '1);

        quo_fix = neg_quo_q ? -quo_q  : quo_q;
        rem_fix = neg_rem_q ? -prem_q : prem_q;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        div_zero_q <= 1'b0;
                        overflow_q <= 1'b0;
                        if (divisor == '0) begin
                            // Divide-by-zero skips CALC; FIX publishes it uncorrected
                            quo_q     <= '1;
                            prem_q    <= dividend;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            dz_q      <= 1'b1;
                            ovf_q     <= 1'b0;
                            state_q   <= S_FIX;
                        end else begin
                            quo_q     <= a_mag;
                            prem_q    <= '0;
                            dsr_q     <= b_mag;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            dz_q      <= 1'b0;
                            ovf_q     <= ovf_det;
                            cnt_q     <= CW'(N);
                            state_q   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prem_q <= prem_d;
                    quo_q  <= quo_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    // MIN / -1 needs no special case: |MIN| negated wraps back to MIN
                    quotient_q  <= quo_fix;
                    remainder_q <= rem_fix;
                    div_zero_q  <= dz_q;
                    overflow_q  <= ovf_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_divider_seq_hs.sv
// Directed bench for divider_seq_hs at N=8 with hand-computed results.
module tb_divider_seq_hs;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       is_signed;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       overflow;

    int vectors;
    int miscompares;

    divider_seq_hs #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one accept edge, then scramble the inputs
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = 8'h3C;
        divisor   = 8'h00;
        is_signed = ~s;
    endtask

    // Edges after the accept edge until out_valid is seen (bounded)
    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({in_ready, out_valid, quotient, remainder, div_zero, overflow} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b want rdy=1 vld=0 q=00 r=00 dz=0 ov=0",
                     in_ready, out_valid, quotient, remainder, div_zero, overflow);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        logic [7:0] a [3] = '{8'd200, 8'hFF, 8'd5};
        logic [7:0] b [3] = '{8'd7,   8'h01, 8'd9};
        logic [7:0] q [3] = '{8'h1C,  8'hFF, 8'h00};
        logic [7:0] r [3] = '{8'h04,  8'h00, 8'h05};
        int lat;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL unsigned_in_ready[%0d] got %b want 1", i, in_ready);
            end
            issue(a[i], b[i], 1'b0);
            wait_result(lat);
            vectors++;
            if (lat != 9) begin
                miscompares++;
                $display("FAIL unsigned_latency[%0d] got %0d want 9", i, lat);
            end
            vectors++;
            if ({quotient, remainder, div_zero, overflow} !== {q[i], r[i], 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL unsigned_result[%0d] got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=0 ov=0",
                         i, quotient, remainder, div_zero, overflow, q[i], r[i]);
            end
            consume();
            vectors++;
            if ({out_valid, in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL unsigned_consume[%0d] got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] a [3] = '{8'hF9, 8'h07, 8'hF9};
        logic [7:0] b [3] = '{8'h02, 8'hFE, 8'hFE};
        logic [7:0] q [3] = '{8'hFD, 8'hFD, 8'h03};
        logic [7:0] r [3] = '{8'hFF, 8'h01, 8'hFF};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(a[i], b[i], 1'b1);
            wait_result(lat);
            vectors++;
            if (lat != 9) begin
                miscompares++;
                $display("FAIL signed_latency[%0d] got %0d want 9", i, lat);
            end
            vectors++;
            if ({quotient, remainder, div_zero, overflow} !== {q[i], r[i], 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL signed_result[%0d] got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=0 ov=0",
                         i, quotient, remainder, div_zero, overflow, q[i], r[i]);
            end
            consume();
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] a [3] = '{8'h55, 8'h55, 8'h85};
        logic       s [3] = '{1'b0,  1'b1,  1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(a[i], 8'h00, s[i]);
            wait_result(lat);
            vectors++;
            if (lat != 1) begin
                miscompares++;
                $display("FAIL divzero_latency[%0d] got %0d want 1", i, lat);
            end
            vectors++;
            if ({quotient, remainder, div_zero, overflow} !== {8'hFF, a[i], 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL divzero_result[%0d] got q=%h r=%h dz=%b ov=%b want q=ff r=%h dz=1 ov=0",
                         i, quotient, remainder, div_zero, overflow, a[i]);
            end
            consume();
        end
    endtask

    task automatic test_overflow();
        int lat;
        issue(8'h80, 8'hFF, 1'b1);
        wait_result(lat);
        vectors++;
        if (lat != 9) begin
            miscompares++;
            $display("FAIL overflow_latency got %0d want 9", lat);
        end
        vectors++;
        if ({quotient, remainder, div_zero, overflow} !== {8'h80, 8'h00, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_signed got q=%h r=%h dz=%b ov=%b want q=80 r=00 dz=0 ov=1",
                     quotient, remainder, div_zero, overflow);
        end
        consume();
        issue(8'h80, 8'hFF, 1'b0);
        wait_result(lat);
        vectors++;
        if ({quotient, remainder, div_zero, overflow} !== {8'h00, 8'h80, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL overflow_unsigned got q=%h r=%h dz=%b ov=%b want q=00 r=80 dz=0 ov=0",
                     quotient, remainder, div_zero, overflow);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(8'd100, 8'd9, 1'b0);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            dividend  = 8'h11;
            divisor   = 8'h01;
            is_signed = 1'b0;
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, in_ready, quotient, remainder, div_zero, overflow} !== {1'b1, 1'b0, 8'h0B, 8'h01, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_stable[%0d] got vld=%b rdy=%b q=%h r=%h dz=%b ov=%b want vld=1 rdy=0 q=0b r=01 dz=0 ov=0",
                         i, out_valid, in_ready, quotient, remainder, div_zero, overflow);
            end
        end
        in_valid = 1'b0;
        consume();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL hold_ignored_input got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [3] = '{8'd50, 8'hF0, 8'd9};
        logic [7:0] b [3] = '{8'd5,  8'h10, 8'd4};
        logic       s [3] = '{1'b0,  1'b1,  1'b0};
        logic [7:0] q [3] = '{8'h0A, 8'hFF, 8'h02};
        logic [7:0] r [3] = '{8'h00, 8'h00, 8'h01};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(a[i], b[i], s[i]);
            wait_result(lat);
            vectors++;
            if (lat != 9 || {quotient, remainder} !== {q[i], r[i]}) begin
                miscompares++;
                $display("FAIL b2b_result[%0d] got lat=%0d q=%h r=%h want lat=9 q=%h r=%h",
                         i, lat, quotient, remainder, q[i], r[i]);
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL b2b_consume_edge10[%0d] got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int  lat;
        logic seen;
        issue(8'd123, 8'd5, 1'b0);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid, quotient, remainder, div_zero, overflow} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_reset_values got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b want rdy=1 vld=0 q=00 r=00 dz=0 ov=0",
                     in_ready, out_valid, quotient, remainder, div_zero, overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        vectors++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_no_result got vld_seen=%b rdy=%b want vld_seen=0 rdy=1", seen, in_ready);
        end
        issue(8'd255, 8'd255, 1'b0);
        wait_result(lat);
        vectors++;
        if (lat != 9 || {quotient, remainder, div_zero, overflow} !== {8'h01, 8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_next_op got lat=%0d q=%h r=%h dz=%b ov=%b want lat=9 q=01 r=00 dz=0 ov=0",
                     lat, quotient, remainder, div_zero, overflow);
        end
        consume();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        is_signed   = 1'b0;
        dividend    = '0;
        divisor     = '0;
        out_ready   = 1'b0;

        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
